// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer:
// opcodes, state encodings and datapath select codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R_FORM = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_JR     = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R   = 3'd0,
        C_ALU_I   = 3'd1,
        C_MEM     = 3'd2,
        C_BRANCH  = 3'd3,
        C_JUMP    = 3'd4,
        C_ILLEGAL = 3'd5
    } cls_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_REG = 2'd3;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Opcode classifier: next-state class, immediate extension
// and write-address select for the control sequencer.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic       ext_sel,
    output logic       use_rd,
    output logic       is_lw,
    output logic       is_bne,
    output logic       is_jal,
    output logic       is_jr
);

    always_comb begin
        cls = C_ILLEGAL;
        case (op)
            OP_R_FORM: cls = (funct == FN_JR) ? C_JUMP : C_ALU_R;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI: cls = C_ALU_I;
            OP_LW, OP_SW: cls = C_MEM;
            OP_BEQ, OP_BNE: cls = C_BRANCH;
            OP_J, OP_JAL: cls = C_JUMP;
            default: cls = C_ILLEGAL;
        endcase
    end

    assign ext_sel = (op == OP_ANDI) | (op == OP_ORI) | (op == OP_XORI);
    assign use_rd  = (op == OP_R_FORM);
    assign is_lw   = (op == OP_LW);
    assign is_bne  = (op == OP_BNE);
    assign is_jal  = (op == OP_JAL);
    assign is_jr   = (op == OP_R_FORM) && (funct == FN_JR);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives datapath strobes.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Ins,
    input  logic             Zero,
    input  logic             MemAck,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             ExtSel,
    output logic             RegWrite,
    output logic [4:0]       WAddr,
    output logic [1:0]       WdSel,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired,
    output logic [3:0]       State
);

    state_t            state;
    state_t            nxt;
    logic              illegal;
    logic [CNT_W-1:0]  retired;
    logic [2:0]        cls;
    logic              ext_sel;
    logic              use_rd;
    logic              is_lw;
    logic              is_bne;
    logic              is_jal;
    logic              is_jr;
    logic              reg_wr;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              unused_bits;

    assign rt          = Ins[20:16];
    assign rd          = Ins[15:11];
    assign unused_bits = ^{Ins[25:21], Ins[10:6]};

    mc_decode u_decode (
        .op      (Ins[31:26]),
        .funct   (Ins[5:0]),
        .cls     (cls),
        .ext_sel (ext_sel),
        .use_rd  (use_rd),
        .is_lw   (is_lw),
        .is_bne  (is_bne),
        .is_jal  (is_jal),
        .is_jr   (is_jr)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  if (MemAck) nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_ALU_R:  nxt = S_EXEC_R;
                    C_ALU_I:  nxt = S_EXEC_I;
                    C_MEM:    nxt = S_ADDR;
                    C_BRANCH: nxt = S_BRANCH;
                    C_JUMP:   nxt = S_JUMP;
                    default:  nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_ADDR:   nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (MemAck) nxt = S_WB_MEM;
            S_MEM_WR: if (MemAck) nxt = S_FETCH;
            S_WB_ALU, S_WB_MEM,
            S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= nxt;
            if (nxt == S_TRAP) illegal <= 1'b1;
            if (nxt == S_FETCH && state != S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

    // Strobes are gated by reset so a mid-instruction reset never writes.
    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PC_SEQ;
        ALUSrcB  = SRCB_RT;
        ALUOp    = ALU_ADD;
        WdSel    = WD_ALU;
        WAddr    = 5'd0;
        reg_wr   = 1'b0;
        if (RST) begin
            case (state)
                S_FETCH: begin
                    MemReq  = 1'b1;
                    IRWrite = MemAck;
                    PCWrite = MemAck;
                end
                S_DECODE: ALUSrcB = SRCB_IMM_SH;
                S_EXEC_R: ALUOp = ALU_FUNCT;
                S_EXEC_I: begin
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_IMM;
                end
                S_ADDR: ALUSrcB = SRCB_IMM;
                S_MEM_RD: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                end
                S_MEM_WR: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_WB_ALU: begin
                    reg_wr = 1'b1;
                    WAddr  = use_rd ? rd : rt;
                end
                S_WB_MEM: begin
                    reg_wr = 1'b1;
                    WdSel  = WD_MEM;
                    WAddr  = rt;
                end
                S_BRANCH: begin
                    ALUOp   = ALU_SUB;
                    PCSrc   = PC_BR;
                    PCWrite = Zero ^ is_bne;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = is_jr ? PC_REG : PC_JMP;
                    if (is_jal) begin
                        reg_wr = 1'b1;
                        WAddr  = 5'd31;
                        WdSel  = WD_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RegWrite = reg_wr && (WAddr != 5'd0);
    assign ExtSel   = RST && ext_sel;
    assign Illegal  = illegal;
    assign Retired  = retired;
    assign State    = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: randomized instruction stream with a
// memory responder, expected strobe events derived per instruction.
module tb_mc_ctrl;

    localparam logic [5:0] R_ = 6'h00, J_ = 6'h02, JAL_ = 6'h03;
    localparam logic [5:0] BEQ_ = 6'h04, BNE_ = 6'h05, ADDI_ = 6'h08;
    localparam logic [5:0] SLTI_ = 6'h0A, ANDI_ = 6'h0C, ORI_ = 6'h0D;
    localparam logic [5:0] XORI_ = 6'h0E, LW_ = 6'h23, SW_ = 6'h2B;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Ins = 32'h0;
    logic        Zero = 1'b0;
    logic        MemAck = 1'b0;
    logic        MemReq, MemWrite, IorD, IRWrite, PCWrite;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp, WdSel;
    logic        ExtSel, RegWrite, Illegal;
    logic [4:0]  WAddr;
    logic [31:0] Retired;
    logic [3:0]  State;

    mc_ctrl dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Zero(Zero), .MemAck(MemAck),
        .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .RegWrite(RegWrite), .WAddr(WAddr), .WdSel(WdSel),
        .Illegal(Illegal), .Retired(Retired), .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ins;
        logic        zero;
        int          wf;
        int          wm;
        int          idx;
    } item_t;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       mem;
        logic       iord;
        logic       mw;
        logic       rw;
        logic [4:0] waddr;
        logic [1:0] wdsel;
        logic [1:0] srcb;
        logic [1:0] aluop;
    } ev_t;

    typedef struct {
        ev_t ev;
        int  retired;
        int  gap;
    } exp_t;

    item_t prog_q[$];
    exp_t  exp_q[$];
    item_t cur, nxt, last;
    bit    nxt_ok = 0;
    bit    have_last = 0;
    bit    cur_ext = 0;
    int    n_loaded = 0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_fetch = 0;
    logic [5:0] ops [12] = '{R_, ADDI_, SLTI_, ANDI_, ORI_, XORI_,
                             LW_, SW_, BEQ_, BNE_, J_, JAL_};

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic item_t mk(logic [31:0] ins, logic z, int wf, int wm);
        item_t it;
        it.ins = ins; it.zero = z; it.wf = wf; it.wm = wm; it.idx = 0;
        return it;
    endfunction

    function automatic item_t rnd_item();
        logic [31:0] ins;
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 11)];
        if (ins[31:26] == R_ && $urandom_range(0, 4) == 0)
            ins[5:0] = 6'h08;
        return mk(ins, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 2));
    endfunction

    function automatic bit ext_of(logic [5:0] op);
        return op == ANDI_ || op == ORI_ || op == XORI_;
    endfunction

    // Cycles from fetch completion to the next FETCH, zero fetch wait.
    function automatic int lat(item_t it);
        logic [5:0] op;
        op = it.ins[31:26];
        if (op == LW_) return 5 + it.wm;
        if (op == SW_) return 4 + it.wm;
        if (op inside {BEQ_, BNE_, J_, JAL_}) return 3;
        if (op == R_ && it.ins[5:0] == 6'h08) return 3;
        return 4;
    endfunction

    task automatic push(ev_t e, int r, int g);
        exp_t x;
        x.ev = e; x.retired = r; x.gap = g;
        exp_q.push_back(x);
    endtask

    task automatic issue(item_t it);
        ev_t e;
        logic [5:0] op;
        logic [4:0] rt, rd;
        op = it.ins[31:26];
        rt = it.ins[20:16];
        rd = it.ins[15:11];
        e = '0; e.irw = 1; e.pcw = 1; e.mem = 1;
        push(e, it.idx, have_last ? lat(last) + it.wf : 0);
        e = '0;
        if (op == R_ && it.ins[5:0] == 6'h08) begin
            e.pcw = 1; e.pcsrc = 2'd3; push(e, -1, 0);
        end else if (op == R_) begin
            if (rd != 0) begin e.rw = 1; e.waddr = rd; push(e, -1, 0); end
        end else if (op inside {ADDI_, SLTI_, ANDI_, ORI_, XORI_}) begin
            if (rt != 0) begin e.rw = 1; e.waddr = rt; push(e, -1, 0); end
        end else if (op == LW_) begin
            e.mem = 1; e.iord = 1; push(e, -1, 0);
            e = '0;
            if (rt != 0) begin
                e.rw = 1; e.waddr = rt; e.wdsel = 2'd1; push(e, -1, 0);
            end
        end else if (op == SW_) begin
            e.mem = 1; e.iord = 1; e.mw = 1; push(e, -1, 0);
        end else if (op == BEQ_ || op == BNE_) begin
            if (it.zero ^ (op == BNE_)) begin
                e.pcw = 1; e.pcsrc = 2'd1; e.aluop = 2'd1; push(e, -1, 0);
            end
        end else if (op == J_ || op == JAL_) begin
            e.pcw = 1; e.pcsrc = 2'd2;
            if (op == JAL_) begin e.rw = 1; e.waddr = 5'd31; e.wdsel = 2'd2; end
            push(e, -1, 0);
        end
    endtask

    task automatic load_next();
        if (prog_q.size() > 0) begin
            nxt = prog_q.pop_front();
            nxt.idx = n_loaded++;
            issue(nxt);
            last = nxt;
            have_last = 1;
            nxt_ok = 1;
        end else begin
            nxt_ok = 0;
        end
    endtask

    // Memory responder: counts per-access wait cycles, loads the IR.
    initial begin
        bit sreq, sack, siord;
        int wcnt;
        wcnt = -1;
        forever begin
            @(negedge CLK);
            sreq = MemReq; sack = MemAck; siord = IorD;
            @(posedge CLK);
            #1;
            if (!RST) begin
                MemAck = 0;
                wcnt = -1;
            end else begin
                if (sreq && sack) begin
                    wcnt = -1;
                    if (!siord) begin
                        cur = nxt;
                        Ins = cur.ins;
                        Zero = cur.zero;
                        cur_ext = ext_of(cur.ins[31:26]);
                        load_next();
                    end
                end
                if (MemReq) begin
                    if (wcnt < 0)
                        wcnt = IorD ? cur.wm : (nxt_ok ? nxt.wf : 1000000);
                    if (wcnt == 0) MemAck = 1;
                    else begin MemAck = 0; wcnt--; end
                end else begin
                    MemAck = ($urandom_range(0, 3) == 0);
                    wcnt = -1;
                end
            end
        end
    end

    // Monitor: pops one expected event per visible strobe event.
    initial begin
        ev_t a;
        exp_t x;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                if (State == 4'd1)
                    chk("decode_alu", {ALUSrcB, ALUOp}, 4'b1100);
                if (State != 4'd0)
                    chk("extsel", ExtSel, cur_ext);
                if (RegWrite || PCWrite || (MemReq && MemAck)) begin
                    a = '0;
                    a.irw = IRWrite;
                    a.pcw = PCWrite;
                    a.pcsrc = PCWrite ? PCSrc : 2'd0;
                    a.mem = MemReq && MemAck;
                    a.iord = a.mem ? IorD : 1'b0;
                    a.mw = a.mem ? MemWrite : 1'b0;
                    a.rw = RegWrite;
                    a.waddr = RegWrite ? WAddr : 5'd0;
                    a.wdsel = RegWrite ? WdSel : 2'd0;
                    a.srcb = ALUSrcB;
                    a.aluop = ALUOp;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", a, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("event", a, x.ev);
                        if (x.retired >= 0)
                            chk("retired", Retired, x.retired);
                        if (a.irw) begin
                            if (x.gap > 0)
                                chk("latency", cyc - last_fetch, x.gap);
                            last_fetch = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST = 0;
        exp_q.delete();
        #1;
        chk("rst_strobes",
            {MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite}, 0);
        @(posedge CLK);
        #1;
        chk("rst_state", State, 0);
        chk("rst_retired", Retired, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_waddr", WAddr, 0);
        n_loaded = 0;
        have_last = 0;
    endtask

    task automatic release_rst();
        load_next();
        @(posedge CLK);
        #2;
        RST = 1;
        #1;
        chk("first_memreq", MemReq, 1);
    endtask

    initial begin
        int n;
        do_reset();
        prog_q.push_back(mk({6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20}, 0, 0, 0));
        prog_q.push_back(mk({LW_, 5'd1, 5'd9, 16'h0004}, 0, 0, 2));
        prog_q.push_back(mk({BNE_, 5'd1, 5'd2, 16'h0010}, 0, 0, 0));
        prog_q.push_back(mk({BNE_, 5'd1, 5'd2, 16'h0010}, 1, 0, 0));
        prog_q.push_back(mk({JAL_, 26'h0000040}, 0, 0, 0));
        prog_q.push_back(mk({ORI_, 5'd3, 5'd0, 16'h8000}, 0, 0, 0));
        prog_q.push_back(mk({SW_, 5'd1, 5'd4, 16'h0008}, 0, 1, 1));
        prog_q.push_back(mk({6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 6'h08}, 0, 0, 0));
        prog_q.push_back(mk({BEQ_, 5'd1, 5'd2, 16'h0003}, 1, 2, 0));
        for (int i = 0; i < 200; i++) prog_q.push_back(rnd_item());
        prog_q.push_back(mk(32'hFC00_0000, 0, 0, 0));
        release_rst();

        n = 0;
        while (!Illegal && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        chk("trap_reached", Illegal, 1);
        repeat (6) begin
            @(negedge CLK);
            chk("trap_state", State, 4'd11);
            chk("trap_noreq", MemReq, 0);
        end
        chk("queue_drained", exp_q.size(), 0);

        do_reset();
        prog_q.push_back(mk({6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20}, 0, 0, 0));
        prog_q.push_back(mk({SW_, 5'd1, 5'd4, 16'h0008}, 0, 0, 100000));
        release_rst();
        n = 0;
        while (State != 4'd6 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_mem_wr", State, 4'd6);
        repeat (2) @(negedge CLK);
        chk("memwr_req", {MemReq, MemWrite, IorD}, 3'b111);
        chk("memwr_retired", Retired, 1);
        @(posedge CLK);
        #2;
        RST = 0;
        #1;
        chk("memwr_rst_drop", {MemReq, MemWrite}, 2'b00);
        exp_q.delete();
        @(posedge CLK);
        #1;
        chk("memwr_rst_state", State, 0);
        chk("memwr_rst_retired", Retired, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
